// File: rtl/branch_predict_btb_if.sv
// Lookup, update and statistics signals between the fetch/resolve stages and the BTB.
// The master drives PCs and resolved outcomes. The slave (the BTB) returns predictions and counters.
interface branch_predict_btb_if #(
  parameter int WORD_W = 32,
  parameter int STAT_W = 16
);
  logic [WORD_W-1:0] lkp_pc;
  logic              lkp_hit;
  logic              lkp_taken;
  logic [WORD_W-1:0] lkp_target;
  logic              upd_valid;
  logic [WORD_W-1:0] upd_pc;
  logic              upd_uncond;
  logic              upd_taken;
  logic [WORD_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [WORD_W-1:0] upd_pred_target;
  logic              mispredict;
  logic              flush_all;
  logic [STAT_W-1:0] stat_hits;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output lkp_pc, upd_valid, upd_pc, upd_uncond, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, flush_all,
    input  lkp_hit, lkp_taken, lkp_target, mispredict, stat_hits, stat_mispred
  );

  modport slave (
    input  lkp_pc, upd_valid, upd_pc, upd_uncond, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, flush_all,
    output lkp_hit, lkp_taken, lkp_target, mispredict, stat_hits, stat_mispred
  );
endinterface

// File: rtl/branch_predict_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// It also keeps saturating hit and mispredict statistics for the MIPS fetch stage.
module branch_predict_btb #(
  parameter int WORD_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input logic CLK,
  input logic nRST,
  branch_predict_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_W - IDX_W - 2;
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]  CTR_ONE  = 1;
  localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_ONE << (CTR_W - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_ONE = 1;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [WORD_W-1:0]  targets [ENTRIES];
  logic [CTR_W-1:0]   ctrs    [ENTRIES];

  logic [IDX_W-1:0]  lkp_idx, upd_idx;
  logic [TAG_W-1:0]  lkp_tag, upd_tag;
  logic              lkp_hit_int, upd_hit;
  logic [STAT_W-1:0] stat_hits_q, stat_mispred_q;
  logic              unused_lsbs;

  assign lkp_idx     = bus.lkp_pc[IDX_W+1:2];
  assign lkp_tag     = bus.lkp_pc[WORD_W-1:IDX_W+2];
  assign upd_idx     = bus.upd_pc[IDX_W+1:2];
  assign upd_tag     = bus.upd_pc[WORD_W-1:IDX_W+2];
  assign unused_lsbs = ^{bus.lkp_pc[1:0], bus.upd_pc[1:0]};

  // Lookup reads stored state only, so a same-cycle update is never bypassed.
  always_comb begin
    lkp_hit_int    = valid[lkp_idx] && (tags[lkp_idx] == lkp_tag);
    upd_hit        = valid[upd_idx] && (tags[upd_idx] == upd_tag);
    bus.lkp_hit    = lkp_hit_int;
    bus.lkp_taken  = lkp_hit_int && ctrs[lkp_idx][CTR_W-1];
    bus.lkp_target = lkp_hit_int ? targets[lkp_idx] : '0;
    bus.mispredict = bus.upd_valid &&
                     ((bus.upd_taken != bus.upd_pred_taken) ||
                      (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i]    <= '0;
        targets[i] <= '0;
        ctrs[i]    <= '0;
      end
    end else if (bus.flush_all) begin
      valid <= '0;
    end else if (bus.upd_valid) begin
      if (upd_hit) begin
        if (bus.upd_uncond) begin
          ctrs[upd_idx]    <= CTR_MAX;
          targets[upd_idx] <= bus.upd_target;
        end else if (bus.upd_taken) begin
          if (ctrs[upd_idx] != CTR_MAX)
            ctrs[upd_idx] <= ctrs[upd_idx] + CTR_ONE;
          targets[upd_idx] <= bus.upd_target;
        end else if (ctrs[upd_idx] != '0) begin
          ctrs[upd_idx] <= ctrs[upd_idx] - CTR_ONE;
        end
      end else if (bus.upd_taken) begin
        // Allocation evicts whatever aliasing entry lived at this index.
        valid[upd_idx]   <= 1'b1;
        tags[upd_idx]    <= upd_tag;
        targets[upd_idx] <= bus.upd_target;
        ctrs[upd_idx]    <= bus.upd_uncond ? CTR_MAX : CTR_WEAK;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_hits_q    <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (lkp_hit_int && (stat_hits_q != STAT_MAX))
        stat_hits_q <= stat_hits_q + STAT_ONE;
      if (bus.mispredict && (stat_mispred_q != STAT_MAX))
        stat_mispred_q <= stat_mispred_q + STAT_ONE;
    end
  end

  assign bus.stat_hits    = stat_hits_q;
  assign bus.stat_mispred = stat_mispred_q;
endmodule

// File: tb/tb_branch_predict_btb.sv
// Scoreboard bench for branch_predict_btb: directed rows push hand-computed expectations,
// and a negedge monitor pops and compares them.
module tb_branch_predict_btb;
  logic CLK = 1'b0;
  logic nRST = 1'b0;

  typedef struct {
    int          row;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        misp;
    logic [3:0]  hits;
    logic [3:0]  mispred;
  } exp_t;

  exp_t exp_q[$];
  logic chk_valid = 1'b0;
  int   row_num = 0;
  int   compared = 0;
  int   mismatched = 0;

  branch_predict_btb_if #(.WORD_W(32), .STAT_W(4)) bus ();

  branch_predict_btb #(.WORD_W(32), .ENTRIES(16), .CTR_W(2), .STAT_W(4)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string name, input int row, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL row %0d %s: got 0x%0h, expected 0x%0h", row, name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("lkp_hit",      e.row, 32'(bus.lkp_hit),      32'(e.hit));
    cmp("lkp_taken",    e.row, 32'(bus.lkp_taken),    32'(e.taken));
    cmp("lkp_target",   e.row, bus.lkp_target,        e.target);
    cmp("mispredict",   e.row, 32'(bus.mispredict),   32'(e.misp));
    cmp("stat_hits",    e.row, 32'(bus.stat_hits),    32'(e.hits));
    cmp("stat_mispred", e.row, 32'(bus.stat_mispred), 32'(e.mispred));
  endtask

  always @(negedge CLK) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard: output sampled with no expectation queued");
      end else begin
        checkOutput(exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(
    input logic [31:0] lkp, input logic uv, input logic [31:0] upc, input logic unc,
    input logic tk, input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
    input logic fl, input logic rst,
    input logic eh, input logic et, input logic [31:0] etgt, input logic em,
    input logic [3:0] eH, input logic [3:0] eM);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST                = ~rst;
    bus.lkp_pc          = lkp;
    bus.upd_valid       = uv;
    bus.upd_pc          = upc;
    bus.upd_uncond      = unc;
    bus.upd_taken       = tk;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = pt;
    bus.upd_pred_target = ptgt;
    bus.flush_all       = fl;
    row_num++;
    e.row = row_num; e.hit = eh; e.taken = et; e.target = etgt;
    e.misp = em; e.hits = eH; e.mispred = eM;
    exp_q.push_back(e);
    chk_valid = 1'b1;
  endtask

  task automatic lookupRow(input logic [31:0] lkp, input logic eh, input logic et,
                           input logic [31:0] etgt, input logic [3:0] eH, input logic [3:0] eM);
    applyStimulus(lkp, 0, 0, 0, 0, 0, 0, 0, 0, 0, eh, et, etgt, 0, eH, eM);
  endtask

  initial begin
    bus.lkp_pc = 32'h3C; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_uncond = 0;
    bus.upd_taken = 0; bus.upd_target = 0; bus.upd_pred_taken = 0;
    bus.upd_pred_target = 0; bus.flush_all = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Reset state and first allocation
    lookupRow(32'h40, 0, 0, 0, 0, 0);
    applyStimulus(32'h3C, 1, 32'h40, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    lookupRow(32'h40, 1, 1, 32'h100, 0, 1);
    // Counter training: saturate at 3, then walk down to 0
    repeat (3) applyStimulus(32'h3C, 1, 32'h40, 0, 1, 32'h100, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(32'h3C, 1, 32'h40, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 1);
    applyStimulus(32'h3C, 1, 32'h40, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 2);
    lookupRow(32'h40, 1, 0, 32'h100, 1, 3);
    applyStimulus(32'h3C, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3);
    lookupRow(32'h40, 1, 0, 32'h100, 2, 3);
    // Direction right but target wrong still counts as a mispredict
    applyStimulus(32'h3C, 1, 32'h40, 0, 1, 32'h104, 1, 32'h100, 0, 0, 0, 0, 0, 1, 3, 3);
    lookupRow(32'h40, 1, 0, 32'h104, 3, 4);
    // Aliasing at index 0
    applyStimulus(32'h3C, 1, 32'h80, 0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 1, 4, 4);
    lookupRow(32'h40, 0, 0, 0, 4, 5);
    lookupRow(32'h80, 1, 1, 32'h200, 4, 5);
    applyStimulus(32'h3C, 1, 32'hC0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    lookupRow(32'h80, 1, 1, 32'h200, 5, 5);
    lookupRow(32'hC0, 0, 0, 0, 6, 5);
    // Unconditional allocation, then re-train 0x40 to ctr=1
    applyStimulus(32'h3C, 1, 32'h44, 1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1, 6, 5);
    applyStimulus(32'h3C, 1, 32'h40, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 6, 6);
    applyStimulus(32'h44, 1, 32'h40, 0, 0, 0, 1, 32'h100, 0, 0, 1, 1, 32'h300, 1, 6, 7);
    // Same-cycle lookup/update sees the old counter
    applyStimulus(32'h40, 1, 32'h40, 0, 1, 32'h100, 0, 0, 0, 0, 1, 0, 32'h100, 1, 7, 8);
    lookupRow(32'h40, 1, 1, 32'h100, 8, 9);
    // Flush beats the simultaneous update
    applyStimulus(32'h44, 1, 32'h48, 0, 1, 32'h400, 1, 32'h400, 1, 0, 1, 1, 32'h300, 0, 9, 9);
    lookupRow(32'h40, 0, 0, 0, 10, 9);
    lookupRow(32'h44, 0, 0, 0, 10, 9);
    lookupRow(32'h48, 0, 0, 0, 10, 9);
    // Hit counter saturation
    applyStimulus(32'h3C, 1, 32'h40, 0, 1, 32'h100, 1, 32'h100, 0, 0, 0, 0, 0, 0, 10, 9);
    for (int k = 0; k < 20; k++)
      lookupRow(32'h40, 1, 1, 32'h100, ((10 + k) > 15) ? 4'd15 : 4'(10 + k), 9);
    lookupRow(32'h3C, 0, 0, 0, 15, 9);
    // Asynchronous reset mid-run
    applyStimulus(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    lookupRow(32'h40, 0, 0, 0, 0, 0);

    @(posedge CLK);
    #1 chk_valid = 1'b0;
    repeat (2) @(posedge CLK);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/branch_predict_btb.md
Name: branch_predict_btb

Overview:
- Parametrised branch target buffer with saturating-counter direction prediction for the 5-stage pipelined MIPS core.
- Fetch looks up the current PC combinationally to obtain a predicted next PC.
- The branch-resolve stage sends the actual outcome back through the update port.
- The block keeps saturating hit and mispredict statistics, and its combinational mispredict flag drives the pipeline flush.

Parameters:
- WORD_W, 32: address/data width (PC and target width).
- ENTRIES, 16: number of BTB entries; power of 2, minimum 2.
- CTR_W, 2: direction counter width; minimum 1.
- STAT_W, 16: width of the hit and mispredict statistic counters.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset, asynchronous, active-low.
- lkp_pc  input  WORD_W  fetch-stage PC to look up.
- lkp_hit  output  1  valid entry whose tag matches lkp_pc.
- lkp_taken  output  1  predict taken (lkp_hit AND counter MSB).
- lkp_target  output  WORD_W  predicted target; 0 when lkp_hit=0.
- upd_valid  input  1  resolved control-transfer instruction this cycle.
- upd_pc  input  WORD_W  PC of the resolved instruction.
- upd_uncond  input  1  1 = J/JAL, 0 = conditional branch.
- upd_taken  input  1  actual direction.
- upd_target  input  WORD_W  actual target.
- upd_pred_taken  input  1  prediction that was carried down the pipe with the instruction.
- upd_pred_target  input  WORD_W  predicted target that was carried down the pipe.
- mispredict  output  1  combinational misprediction flag for the current update.
- flush_all  input  1  synchronous invalidate of all entries.
- stat_hits  output  STAT_W  count of lookups that hit.
- stat_mispred  output  STAT_W  count of mispredictions.

Behaviour:
- Address split:
  - IDX_W = log2(ENTRIES).
  - idx = pc[IDX_W+1:2].
  - tag = pc[WORD_W-1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry state: valid, tag, target[WORD_W], ctr[CTR_W].
- Reset (nRST low, async):
  - All valid=0, all ctr=0, all targets=0.
  - stat_hits=0, stat_mispred=0.
  - lkp_hit, lkp_taken and lkp_target read 0.
  - mispredict follows its inputs (upd_valid is 0 in reset).
- Lookup:
  - Purely combinational from stored state, zero-cycle latency.
  - A hit requires valid AND tag match.
  - On a miss: lkp_taken=0, lkp_target=0.
- mispredict = upd_valid AND ((upd_taken != upd_pred_taken) OR (upd_taken AND upd_target != upd_pred_target)).
- Update, on the posedge when upd_valid=1; "hit" means the entry at upd idx is valid with a matching tag.
  - Hit, conditional: ctr increments saturating at 2^CTR_W-1 if taken, decrements saturating at 0 if not taken. Target is overwritten with upd_target only when taken.
  - Hit, unconditional: ctr set to all ones; target overwritten.
  - Miss and taken: allocate, replacing any aliasing entry. Set valid=1, tag, target. ctr = all ones if upd_uncond, else 2^(CTR_W-1) (weakly taken).
  - Miss and not taken: no state change.
- Same-cycle lookup and update to the same index:
  - The lookup sees pre-update state (no bypass).
  - The update is visible to lookups from the next cycle.
- flush_all:
  - Clears all valid bits on the posedge.
  - Has priority over a simultaneous update; that update is dropped.
  - Counters and targets are left stale but unreachable.
  - Statistics are unaffected.
- Statistics:
  - stat_hits increments each cycle lkp_hit=1.
  - stat_mispred increments each cycle mispredict=1.
  - Both saturate at all ones (no wrap).
- CTR_W=1: counter degenerates to last-outcome; "weakly taken" = 1.

Test Plan:
- Reset, then lkp_pc=0x40 -> lkp_hit=0, lkp_taken=0, lkp_target=0, stat_hits=0.
- Update pc=0x40, cond, taken, target=0x100, pred_taken=0 -> mispredict=1 same cycle. Next cycle lookup 0x40 gives hit=1, taken=1, target=0x100, ctr=2. stat_mispred=1.
- Counter training:
  - Three taken updates at 0x40 -> ctr saturates at 3.
  - Then two not-taken -> ctr=1, lookup taken=0.
  - One more not-taken -> ctr=0, hit still 1.
- Aliasing:
  - Entry at 0x40 (idx0, tag1).
  - Taken update at 0x80 (idx0, tag2), target 0x200.
  - Lookup 0x40 -> hit=0; lookup 0x80 -> hit=1, target=0x200.
  - Not-taken miss at 0xC0 -> no change.
- Same cycle: lookup 0x40 and update 0x40 taken from ctr=1 -> lkp_taken=0 this cycle, 1 next cycle. Separately, flush_all asserted with an update -> all lookups miss afterwards.
- Statistics saturation (STAT_W=4): 20 consecutive hits -> stat_hits=15 and holds. Assert nRST mid-run -> all outputs return to reset values immediately.
